// File: rtl/ledgame_pkg.sv
// Shared types and helpers for the four-LED toggle game.
// Optional macro: AUTOPLAY_VERIFY_EN (final LED check in autoplay).
package ledgame_pkg;

  localparam int LED_COUNT       = 4;
  localparam int GAP_CYCLES_DEF  = 50_000_000;

  typedef enum logic [2:0] {
    AP_IDLE,
    AP_SOLVE,
    AP_PRESS,
    AP_GAP,
    AP_CHECK,
    AP_DONE,
    AP_FAIL
  } ap_state_e;

  // Button j toggles LED j and LED j-1 (wrapping).
  function automatic logic [LED_COUNT-1:0] toggle_mask(input int j);
    logic [LED_COUNT-1:0] m;
    m = '0;
    m[j % LED_COUNT] = 1'b1;
    m[(j + LED_COUNT - 1) % LED_COUNT] = 1'b1;
    return m;
  endfunction

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  // Isolate the lowest set bit (two's-complement trick).
  function automatic logic [3:0] lowest_bit(input logic [3:0] v);
    return v & (~v + 4'd1);
  endfunction

endpackage

// File: rtl/lights_solver.sv
// Combinational GF(2) solver: press vector that lights all LEDs.
// Picks the lower-popcount of the two solutions, ties go to x[0]=0.
module lights_solver
  import ledgame_pkg::*;
(
  input  logic [LED_COUNT-1:0] led,
  output logic [LED_COUNT-1:0] x,
  output logic                 solvable
);

  logic [LED_COUNT-1:0] d;
  logic [LED_COUNT-1:0] a;
  logic [LED_COUNT-1:0] b;

  // Chain x[k+1] = x[k] ^ d[k] from x[0]=0; complement is the other root.
  always_comb begin
    d = ~led;
    a = '0;
    for (int k = 0; k < LED_COUNT - 1; k++) begin
      a[k+1] = a[k] ^ d[k];
    end
    b = ~a;
    solvable = ~^d;
    x = (popcnt4(b) < popcnt4(a)) ? b : a;
  end

endmodule

// File: rtl/autoplay_sequencer.sv
// Auto-solve driver: captures LEDs, solves, replays spaced presses.
// Optional macro: AUTOPLAY_VERIFY_EN (CHECK compares live led to all-lit).
module autoplay_sequencer
  import ledgame_pkg::*;
#(
  parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LED_COUNT-1:0] led,
  output logic [LED_COUNT-1:0] press,
  output logic                 busy,
  output logic                 done,
  output logic                 fail
);

  localparam int CW = $clog2(GAP_CYCLES + 1);

  ap_state_e            state_q, state_d;
  logic [LED_COUNT-1:0] cap_q, cap_d;
  logic [LED_COUNT-1:0] x_q, x_d;
  logic                 solv_q, solv_d;
  logic [LED_COUNT-1:0] cur_q, cur_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [LED_COUNT-1:0] press_q, press_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 fail_q, fail_d;

  logic [LED_COUNT-1:0] sol_x;
  logic                 sol_ok;
  logic [LED_COUNT-1:0] pend;

  lights_solver u_solver (
    .led      (cap_q),
    .x        (sol_x),
    .solvable (sol_ok)
  );

  // Presses still to issue: bits of x strictly above the current one.
  assign pend = x_q & ~((cur_q << 1) - 4'd1);

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    x_d     = x_q;
    solv_d  = solv_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    press_d = '0;
    busy_d  = busy_q;
    done_d  = done_q;
    fail_d  = fail_q;
    unique case (state_q)
      AP_IDLE: begin
        if (start) begin
          cap_d   = led;
          done_d  = 1'b0;
          fail_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = AP_SOLVE;
        end
      end
      AP_SOLVE: begin
        x_d    = sol_x;
        solv_d = sol_ok;
        if (!sol_ok) begin
          state_d = AP_FAIL;
        end else if (sol_x == '0) begin
          state_d = AP_CHECK;
        end else begin
          cur_d   = lowest_bit(sol_x);
          press_d = lowest_bit(sol_x);
          state_d = AP_PRESS;
        end
      end
      AP_PRESS: begin
        cnt_d   = '0;
        state_d = AP_GAP;
      end
      AP_GAP: begin
        if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          cnt_d = '0;
          if (pend != '0) begin
            cur_d   = lowest_bit(pend);
            press_d = lowest_bit(pend);
            state_d = AP_PRESS;
          end else begin
            state_d = AP_CHECK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      AP_CHECK: begin
`ifdef AUTOPLAY_VERIFY_EN
        state_d = (solv_q && led == '1) ? AP_DONE : AP_FAIL;
`else
        state_d = solv_q ? AP_DONE : AP_FAIL;
`endif
      end
      AP_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = AP_IDLE;
      end
      AP_FAIL: begin
        fail_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = AP_IDLE;
      end
      default: state_d = AP_IDLE;
    endcase
  end

  // State and output registers; reset aborts any sequence at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= AP_IDLE;
      cap_q   <= '0;
      x_q     <= '0;
      solv_q  <= 1'b0;
      cur_q   <= '0;
      cnt_q   <= '0;
      press_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      x_q     <= x_d;
      solv_q  <= solv_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
    end
  end

  assign press = press_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign fail  = fail_q;

endmodule

// File: tb/tb_autoplay_sequencer.sv
// Bench for autoplay_sequencer: table, hand sequences, random vs model.
// Honours AUTOPLAY_VERIFY_EN for the injected-press expectation.
module tb_autoplay_sequencer;

  localparam int G = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] led_m = 4'h0;
  logic [3:0] press;
  logic       busy, done, fail;

  int n_vec = 0;
  int n_bad = 0;

`ifdef AUTOPLAY_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  autoplay_sequencer #(.GAP_CYCLES(G)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .led   (led_m),
    .press (press),
    .busy  (busy),
    .done  (done),
    .fail  (fail)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] led;
    logic [3:0] x;
    bit         ok;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference game: button j flips LED j and LED (j+3)%4.
  function automatic logic [3:0] apply(input logic [3:0] l,
                                       input logic [3:0] p);
    logic [3:0] r;
    r = l;
    for (int j = 0; j < 4; j++)
      if (p[j]) begin
        r[j] = ~r[j];
        r[(j + 3) % 4] = ~r[(j + 3) % 4];
      end
    return r;
  endfunction

  // Brute-force search: fewest presses, tie prefers button 0 unpressed.
  task automatic model(input logic [3:0] l, output logic [3:0] x,
                       output bit ok);
    int best;
    logic [3:0] v;
    best = 99;
    x = 4'h0;
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      if (apply(l, v) == 4'hF) begin
        if ($countones(v) < best ||
            ($countones(v) == best && !v[0])) begin
          best = $countones(v);
          x = v;
          ok = 1'b1;
        end
      end
    end
  endtask

  task automatic run(input string tag, input logic [3:0] l0,
                     input logic [3:0] ex, input bit ok,
                     input bit inject, input bit restart);
    int pj[$];
    logic [3:0] pv[$];
    int ej[$];
    logic [3:0] ev[$];
    int jend;
    bit injected;
    bit exp_done;
    led_m = l0;
    injected = 1'b0;
    jend = -1;
    for (int i = 0; i < 4; i++)
      if (ex[i]) begin
        ev.push_back(4'b0001 << i);
        ej.push_back(1 + ev.size() * 0 + (ev.size() - 1) * (G + 1));
      end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 400; j++) begin
      @(negedge clk);
      if (j == 0) begin
        start = 1'b0;
        chk({tag, " busy_after_start"}, int'(busy), 1);
      end
      if (press != 4'h0) begin
        pj.push_back(j);
        pv.push_back(press);
        led_m = apply(led_m, press);
      end else if (inject && !injected && pv.size() > 0) begin
        led_m = apply(led_m, 4'b0001);
        injected = 1'b1;
      end
      if (restart) start = (j == 3);
      if (!busy) begin
        jend = j;
        break;
      end
    end
    start = 1'b0;
    if (jend < 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s timeout: busy still %0d", tag, busy);
    end
    chk({tag, " pulse_count"}, pv.size(), ev.size());
    for (int k = 0; k < pv.size() && k < ev.size(); k++) begin
      chk({tag, " pulse_val"}, int'(pv[k]), int'(ev[k]));
      chk({tag, " pulse_cyc"}, pj[k], ej[k]);
    end
    chk({tag, " end_cyc"}, jend, ok ? 3 + ev.size() * (G + 1) : 2);
    exp_done = ok && (!VERIFY || led_m == 4'hF);
    chk({tag, " done"}, int'(done), int'(exp_done));
    chk({tag, " fail"}, int'(fail), int'(!exp_done));
  endtask

  vec_t tbl[6];

  initial begin
    logic [3:0] rx;
    bit rok;
    logic [3:0] rl;
    tbl[0] = '{4'b1111, 4'b0000, 1'b1};
    tbl[1] = '{4'b0011, 4'b1000, 1'b1};
    tbl[2] = '{4'b0000, 4'b1010, 1'b1};
    tbl[3] = '{4'b0001, 4'b0000, 1'b0};
    tbl[4] = '{4'b0110, 4'b0001, 1'b1};
    tbl[5] = '{4'b1010, 4'b0110, 1'b1};

    #12;
    chk("reset press", int'(press), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset fail", int'(fail), 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 6; i++)
      run($sformatf("tbl%0d", i), tbl[i].led, tbl[i].x, tbl[i].ok,
          1'b0, 1'b0);

    run("inject", 4'b0000, 4'b1010, 1'b1, 1'b1, 1'b0);
    run("restart_ignored", 4'b0000, 4'b1010, 1'b1, 1'b0, 1'b1);

    led_m = 4'b0000;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset busy", int'(busy), 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst press", int'(press), 0);
    chk("async_rst busy", int'(busy), 0);
    chk("async_rst done", int'(done), 0);
    chk("async_rst fail", int'(fail), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst quiet", int'({press, busy}), 0);
    end
    run("after_reset", 4'b0011, 4'b1000, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      rl = 4'($urandom_range(0, 15));
      model(rl, rx, rok);
      run($sformatf("rnd%0d_led%0h", i, rl), rl, rx, rok, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/autoplay_sequencer.md
# autoplay_sequencer

Demo/auto-solve driver for the four-LED toggle game. On request it samples the current LED state, computes a minimal set of button presses that lights all four LEDs, and replays them as single-cycle press pulses, spaced so a viewer can follow them. Its press outputs are OR-ed with the debounced button-press pulses in front of the LED toggle logic, so it acts as a synthetic player.

## Interface
- GAP_CYCLES, 50_000_000 — idle cycles after each press pulse (≥1); counter width = $clog2(GAP_CYCLES+1)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  request a solve; honoured only in IDLE
- led  in  4  current LED state (1 = lit), synchronous to clk
- press  out  4  one-hot single-cycle press pulse; bit i = button i
- busy  out  1  high from accepted start until result is posted
- done  out  1  sequence completed successfully; held until next accepted start
- fail  out  1  puzzle unsolvable or final check mismatch; held until next accepted start

## Operation
- Toggle map: button j toggles LED j and LED (j−1 mod 4). Equivalently, LED i is toggled by buttons i and (i+1 mod 4).
- Solve, over GF(2): d = ~led_captured. Press vector x satisfies x[i] ^ x[i+1 mod 4] = d[i].
  - Solvable iff ^d == 0 (an even number of dark LEDs). Otherwise → FAIL with no presses.
  - Candidate A: x[0]=0, x[k+1]=x[k]^d[k]. Candidate B = ~A.
  - Pick the candidate with lower popcount; on a tie pick A.
- States:
  - IDLE: on start, capture led, clear done/fail, set busy → SOLVE.
  - SOLVE: register x and the solvable flag. Unsolvable → FAIL. x==0 → CHECK. Otherwise → PRESS at the lowest set bit.
  - PRESS: drive press = one-hot of the current index for one cycle → GAP.
  - GAP: count GAP_CYCLES cycles. Then go to PRESS at the next higher set bit of x, or → CHECK after the last one.
  - CHECK: one cycle; result per Configuration → DONE or FAIL.
  - DONE / FAIL: one cycle to post the flag and drop busy → IDLE.
- Presses are issued in ascending button index.
- led is sampled only in IDLE (capture) and CHECK. Mid-sequence changes to led are ignored.
- start while busy is ignored; it is not queued.

## Timing
- Reset values: state IDLE, press=0, busy=0, done=0, fail=0, counter=0.
- Reset asserted mid-sequence aborts immediately. No partial press pulse is emitted after reset deassertion.
- start sampled high on edge N:
  - busy=1 after N.
  - SOLVE at N+1.
  - First press visible in cycle N+2.
- Consecutive press pulses are separated by exactly GAP_CYCLES zero cycles.
- After the last gap: CHECK for 1 cycle, DONE/FAIL for 1 cycle. done or fail rises in the same cycle busy falls.
- Unsolvable case: fail=1 and busy=0 at N+3.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- AUTOPLAY_VERIFY_EN defined: CHECK compares live led to 4'b1111.
  - Equal → done.
  - Mismatch → fail (e.g. a human pressed a button during the sequence).
- AUTOPLAY_VERIFY_EN undefined: CHECK always proceeds to done; led is ignored after capture.

## Structure
- Shared package (ledgame_pkg) holds:
  - LED_COUNT = 4
  - toggle-map function (button → LED mask)
  - autoplay state enum
  - default GAP_CYCLES constant
- One sub-module, lights_solver: combinational; led[3:0] → x[3:0], solvable. The main block registers its outputs in SOLVE.

## Test plan
All cases use GAP_CYCLES=4 and AUTOPLAY_VERIFY_EN defined unless noted; the model applies presses to led.
- led=4'b1111, start → no press pulses; done=1, busy=0 four cycles after the start edge.
- led=4'b0011, start → single pulse press=4'b1000 at N+2 → led 1111 → done.
- led=4'b0000, start → press=4'b0010 at N+2, then press=4'b1000 five cycles later (tie picks candidate A) → done.
- led=4'b0001, start → no presses; fail=1, busy=0 at N+3.
- led=4'b0000, and the model injects an extra button-0 press during the gap → fail. Same stimulus with the macro undefined → done.
- Reset pulled low during GAP → all outputs 0 asynchronously; a new start after release runs a full sequence from the new capture.
